// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O subsystem: data width, debounce defaults
// and the port-select encodings used by the input and output multiplexers.
package io_pkg;

    localparam int DATA_W       = 8;
    localparam int TICK_DIV_DEF = 50000;
    localparam int STABLE_N_DEF = 4;

    typedef enum logic [1:0] {
        PORT_SEL_SWITCHES = 2'd0,
        PORT_SEL_BUTTONS  = 2'd1,
        PORT_SEL_TIMER    = 2'd2,
        PORT_SEL_UART     = 2'd3
    } port_sel_e;

endpackage

// File: rtl/generador_tick.sv
// Free-running sample-tick generator: one-cycle pulse every TICK_DIV clocks.
// Shared with the timer peripheral.
module generador_tick #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tcnt;

    assign tick = (tcnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

endmodule

// File: rtl/entrada_antirrebote.sv
// Debounced input port with optional sticky rising-edge flags cleared by a CPU
// read. Edge-flag logic is built only when ENTRADA_FLANCOS_EN is defined.
module entrada_antirrebote
    import io_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int STABLE_N = STABLE_N_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] port_out,
    output logic [WIDTH-1:0] edge_flags,
    output logic             any_edge
);

    localparam logic [3:0] CNT_LAST = 4'(STABLE_N - 1);

    logic [WIDTH-1:0]      s1;
    logic [WIDTH-1:0]      s2;
    logic [WIDTH-1:0]      deb;
    logic [WIDTH-1:0]      deb_next;
    logic [WIDTH-1:0][3:0] cnt;
    logic [WIDTH-1:0][3:0] cnt_next;
    logic                  tick;

    generador_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    // Any sample that agrees with the accepted level restarts that bit's count.
    always_comb begin
        deb_next = deb;
        cnt_next = cnt;
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb_next[i] = s2[i];
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb <= '0;
            cnt <= '0;
        end else begin
            deb <= deb_next;
            cnt <= cnt_next;
        end
    end

    assign port_out = deb;

`ifdef ENTRADA_FLANCOS_EN
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] flags_q;
    logic [WIDTH-1:0] flags_next;
    logic             any_q;

    // A new rising edge overrides a simultaneous read-clear so no edge is lost.
    assign rise       = deb_next & ~deb;
    assign flags_next = (rd_en ? '0 : flags_q) | rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
            any_q   <= 1'b0;
        end else begin
            flags_q <= flags_next;
            any_q   <= |flags_next;
        end
    end

    assign edge_flags = flags_q;
    assign any_edge   = any_q;
`else
    logic unused_rd_en;

    assign unused_rd_en = rd_en;
    assign edge_flags   = '0;
    assign any_edge     = 1'b0;
`endif

endmodule

// File: tb/tb_entrada_antirrebote.sv
// Directed, scoreboard-driven bench for entrada_antirrebote (TICK_DIV=4, STABLE_N=3).
// Expected flag values follow ENTRADA_FLANCOS_EN as seen by the bench.
module tb_entrada_antirrebote;

    localparam int WIDTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int STABLE_N = 3;

`ifdef ENTRADA_FLANCOS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [7:0] port;
        logic [7:0] flags;
        logic       any;
        int         edge_at;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;

    logic             clk    = 1'b0;
    logic             reset  = 1'b1;
    logic             rd_en  = 1'b0;
    logic [WIDTH-1:0] raw_in = '0;
    logic [WIDTH-1:0] port_out;
    logic [WIDTH-1:0] edge_flags;
    logic             any_edge;

    entrada_antirrebote #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV),
        .STABLE_N (STABLE_N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .rd_en      (rd_en),
        .port_out   (port_out),
        .edge_flags (edge_flags),
        .any_edge   (any_edge)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the sample tick lands on multiples of TICK_DIV.
    always @(posedge clk) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [7:0] fl(input logic [7:0] v);
        return FLAGS_EN ? v : 8'h00;
    endfunction

    function automatic int predict_edge(input int e0);
        int t;
        t = e0 + 3;
        while (t % TICK_DIV != 0) t++;
        return t + (STABLE_N - 1) * TICK_DIV;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] port, input logic [7:0] flags,
                            input int edge_at);
        exp_t e;
        e.tag     = tag;
        e.port    = port;
        e.flags   = fl(flags);
        e.any     = |fl(flags);
        e.edge_at = edge_at;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input string tag, input logic [7:0] value, input logic [7:0] flags_after);
        @(negedge clk);
        raw_in = value;
        push_exp(tag, value, flags_after, predict_edge(edge_cnt));
    endtask

    task automatic check_scoreboard();
        exp_t e;
        int   n;
        if (sb.size() == 0) begin
            check_output("scoreboard_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        n = 0;
        while (port_out !== e.port && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_output({e.tag, "_port"},  32'(port_out),   32'(e.port));
        check_output({e.tag, "_edge"},  32'(edge_cnt),   32'(e.edge_at));
        check_output({e.tag, "_flags"}, 32'(edge_flags), 32'(e.flags));
        check_output({e.tag, "_any"},   32'(any_edge),   32'(e.any));
    endtask

    task automatic read_pulse(input int cycles);
        @(negedge clk);
        rd_en = 1'b1;
        repeat (cycles) @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        int  d;
        int  e0;
        bit  bad;

        // Reset held with every input high.
        raw_in = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_output("reset_port",  32'(port_out),   32'h00);
            check_output("reset_flags", 32'(edge_flags), 32'h00);
            check_output("reset_any",   32'(any_edge),   32'h0);
        end
        reset = 1'b0;
        push_exp("reset_rise", 8'hFF, 8'hFF, predict_edge(0));
        check_scoreboard();
        check_output("reset_latency_max", 32'(edge_cnt <= 14), 32'd1);

        // All inputs fall: level follows, sticky flags untouched.
        apply_stimulus("fall_all", 8'h00, 8'hFF);
        check_scoreboard();

        read_pulse(1);
        check_output("clear0_flags", 32'(edge_flags), 32'h00);
        check_output("clear0_any",   32'(any_edge),   32'h0);

        // Glitch shorter than STABLE_N ticks must be rejected.
        bad = 1'b0;
        @(negedge clk);
        raw_in = 8'h01;
        repeat (6) begin
            @(negedge clk);
            bad |= (port_out !== 8'h00) || (edge_flags !== 8'h00);
        end
        raw_in = 8'h00;
        repeat (24) begin
            @(negedge clk);
            bad |= (port_out !== 8'h00) || (edge_flags !== 8'h00);
        end
        check_output("glitch_stable", 32'(bad),        32'd0);
        check_output("glitch_port",   32'(port_out),   32'h00);
        check_output("glitch_any",    32'(any_edge),   32'h0);

        // Clean press.
        @(negedge clk);
        raw_in = 8'h05;
        e0 = edge_cnt;
        push_exp("press", 8'h05, 8'h05, predict_edge(e0));
        check_scoreboard();
        check_output("press_latency_min", 32'(edge_cnt - e0 >= 11), 32'd1);
        check_output("press_latency_max", 32'(edge_cnt - e0 <= 14), 32'd1);

        read_pulse(1);
        check_output("clear1_flags", 32'(edge_flags), 32'h00);
        check_output("clear1_any",   32'(any_edge),   32'h0);
        check_output("clear1_port",  32'(port_out),   32'h05);

        // Read-clear on the exact edge bit 3 debounces: the set wins.
        @(negedge clk);
        raw_in = 8'h0D;
        d = predict_edge(edge_cnt);
        push_exp("collision", 8'h0D, 8'h08, d);
        for (int n = 0; n < 40 && edge_cnt < d - 1; n++) @(negedge clk);
        check_output("collision_pre_port", 32'(port_out), 32'h05);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check_scoreboard();

        // Release: falling level does not disturb flags.
        apply_stimulus("release", 8'h00, 8'h08);
        check_scoreboard();

        // Back-to-back reads.
        read_pulse(2);
        check_output("b2b_flags", 32'(edge_flags), 32'h00);
        check_output("b2b_any",   32'(any_edge),   32'h0);
        check_output("b2b_port",  32'(port_out),   32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
